// File: rtl/led_matrix_scan.sv
// led_matrix_scan: time-multiplexed LED matrix driver with per-LED mode and PWM level.
// Ports: clk, rst_n (async active-low); wr_en/wr_addr/wr_data shadow-config write port;
//        aled (one-hot row enable), kled_tri (column enables), frame_start (row 0 slot 0 pulse).
module led_matrix_scan #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 4800,
    parameter int BLANK      = 48,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_BITS = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]   wr_addr,
    input  logic [PWM_BITS+1:0]            wr_data,
    output logic [ROWS-1:0]                aled,
    output logic [COLS-1:0]                kled_tri,
    output logic                           frame_start
);

    localparam int N  = ROWS * COLS;
    localparam int DW = PWM_BITS + 2;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [SW-1:0]         slot_q, slot_d;
    logic [RW-1:0]         row_q, row_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic [DW-1:0]         shadow_q [N];
    logic [DW-1:0]         shadow_d [N];
    logic [DW-1:0]         live_q [N];
    logic [DW-1:0]         live_d [N];
    logic [ROWS-1:0]       aled_q, aled_d;
    logic [COLS-1:0]       kled_q, kled_d;
    logic                  frame_start_q, frame_start_d;

    logic                  slot_wrap;
    logic                  row_wrap;
    logic                  frame_wrap;
    logic                  active;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [N-1:0]          led_on;
    logic [COLS-1:0]       row_leds;

    // Counters and configuration copy
    always_comb begin
        slot_wrap  = (slot_q == SW'(SCAN_DIV - 1));
        row_wrap   = (row_q == RW'(ROWS - 1));
        frame_wrap = slot_wrap && row_wrap;

        slot_d  = slot_wrap ? '0 : slot_q + SW'(1);
        row_d   = row_q;
        if (slot_wrap) begin
            row_d = row_wrap ? '0 : row_q + RW'(1);
        end
        blink_d = blink_q + BLINK_BITS'(1);

        shadow_d = shadow_q;
        if (wr_en && (int'(wr_addr) < N)) begin
            shadow_d[wr_addr] = wr_data;
        end

        // Copy uses shadow_d so a write on the wrap clock lands in the new frame.
        live_d = frame_wrap ? shadow_d : live_q;
    end

    // Per-LED lit decision from the live configuration
    assign active  = (slot_q >= SW'(BLANK));
    assign pwm_cnt = PWM_BITS'(slot_q - SW'(BLANK));

    for (genvar i = 0; i < N; i++) begin : g_led
        logic [PWM_BITS-1:0] level;
        logic [1:0]          mode;
        logic                gate;
        logic                level_ok;

        assign level    = live_q[i][PWM_BITS-1:0];
        assign mode     = live_q[i][DW-1:PWM_BITS];
        assign gate     = (mode == 2'd0) ? 1'b0 :
                          (mode == 2'd1) ? 1'b1 :
                          (mode == 2'd2) ? blink_q[BLINK_BITS-1] :
                                           blink_q[BLINK_BITS-3];
        assign level_ok = (level != '0) &&
                          ((level == '1) || (pwm_cnt < level));
        assign led_on[i] = level_ok && gate;
    end

    assign row_leds = led_on[int'(row_q)*COLS +: COLS];

    // Output decode; registered one clock behind the counter state
    always_comb begin
        aled_d        = '0;
        kled_d        = '0;
        frame_start_d = (slot_q == '0) && (row_q == '0);
        if (active) begin
            aled_d = ROWS'(1) << row_q;
            kled_d = row_leds;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= '0;
            row_q         <= '0;
            blink_q       <= '0;
            aled_q        <= '0;
            kled_q        <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
        end else begin
            slot_q        <= slot_d;
            row_q         <= row_d;
            blink_q       <= blink_d;
            aled_q        <= aled_d;
            kled_q        <= kled_d;
            frame_start_q <= frame_start_d;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= shadow_d[i];
                live_q[i]   <= live_d[i];
            end
        end
    end

    assign aled        = aled_q;
    assign kled_tri    = kled_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: randomized bench for led_matrix_scan against a time-indexed model.
// Ports: none; drives clk/rst_n/write port and compares aled/kled_tri/frame_start.
module tb_led_matrix_scan;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SCAN_DIV   = 64;
    localparam int BLANK      = 8;
    localparam int PWM_BITS   = 4;
    localparam int BLINK_BITS = 8;
    localparam int N          = ROWS * COLS;
    localparam int FRAME      = ROWS * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [3:0] aled;
    logic [3:0] kled_tri;
    logic       frame_start;

    led_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .BLANK(BLANK), .PWM_BITS(PWM_BITS), .BLINK_BITS(BLINK_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .aled(aled), .kled_tri(kled_tri), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: t = clocks since reset release (state index the DUT counters hold now)
    int         t;
    logic [5:0] sh [N];
    logic [5:0] lv [N];
    logic [3:0] exp_aled;
    logic [3:0] exp_kled;
    logic       exp_fs;

    function automatic logic model_lit(int tt, int led);
        int slot  = tt % SCAN_DIV;
        int pwm   = (slot - BLANK) % (1 << PWM_BITS);
        int blink = tt % (1 << BLINK_BITS);
        int level = int'(lv[led][3:0]);
        int mode  = int'(lv[led][5:4]);
        bit lvl_ok = (level != 0) && (level == 15 || pwm < level);
        bit gate;
        case (mode)
            0: gate = 0;
            1: gate = 1;
            2: gate = ((blink >> (BLINK_BITS - 1)) & 1) == 1;
            default: gate = ((blink >> (BLINK_BITS - 3)) & 1) == 1;
        endcase
        return lvl_ok && gate;
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) begin
            sh[i] = '0;
            lv[i] = '0;
        end
    endtask

    // Advance one clock: predict outputs for state t, then apply the edge.
    task automatic tick();
        int s = t % SCAN_DIV;
        int r = (t / SCAN_DIV) % ROWS;
        exp_fs   = (t % FRAME) == 0;
        exp_aled = '0;
        exp_kled = '0;
        if (s >= BLANK) begin
            exp_aled = 4'(1 << r);
            for (int c = 0; c < COLS; c++) exp_kled[c] = model_lit(t, r * COLS + c);
        end
        @(posedge clk);
        if (wr_en && int'(wr_addr) < N) sh[wr_addr] = wr_data;
        if (t % FRAME == FRAME - 1) begin
            for (int i = 0; i < N; i++) lv[i] = sh[i];
        end
        t++;
        #1;
    endtask

    task automatic test_reset();
        int fs_cnt = 0;
        int fs_first = -1;
        rst_n = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({aled, kled_tri, frame_start} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_hold got %b/%b/%b want 0", aled, kled_tri, frame_start);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL idle t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = t;
            end
        end
        vectors++;
        if (fs_cnt != 3 || fs_first != 1) begin
            miscompares++;
            $display("FAIL frame_start count=%0d first=%0d want 3 and 1", fs_cnt, fs_first);
        end
    endtask

    task automatic test_full_on();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 6'b01_1111;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL full_on t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
            if (k >= FRAME && (t - 1) % FRAME == SCAN_DIV + 20) begin
                vectors++;
                if (aled !== 4'b0010 || kled_tri !== 4'b0010) begin
                    miscompares++;
                    $display("FAIL full_on_row1 got %b/%b want 0010/0010", aled, kled_tri);
                end
            end
        end
    endtask

    task automatic test_pwm();
        int lit = 0;
        int want = 0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 6'b01_0100;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL pwm t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
            if (k >= FRAME && (t - 1) % FRAME < SCAN_DIV && kled_tri[0]) lit++;
        end
        for (int s = BLANK; s < SCAN_DIV; s++) if ((s - BLANK) % 16 < 4) want++;
        vectors++;
        if (lit != want) begin
            miscompares++;
            $display("FAIL pwm_duty got %0d want %0d", lit, want);
        end
    endtask

    task automatic test_shadow();
        int early = 0;
        while (t % FRAME != 2 * SCAN_DIV + 12) tick();
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 6'b01_1111;
        tick();
        wr_en = 1'b0;
        while (t % FRAME != 0) begin
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL shadow t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
            if (kled_tri[3] && aled[3]) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL shadow_tear got %0d lit clocks want 0", early);
        end
        while (t % FRAME != FRAME - 1) begin
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL shadow_next t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
        end
        wr_en = 1'b1; wr_addr = 4'd14; wr_data = 6'b01_1111;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL shadow_bound t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
            if ((t - 1) % FRAME == 3 * SCAN_DIV + 20) begin
                vectors++;
                if (aled !== 4'b1000 || kled_tri !== 4'b1100) begin
                    miscompares++;
                    $display("FAIL boundary_write got %b/%b want 1000/1100", aled, kled_tri);
                end
            end
        end
    endtask

    task automatic test_blink();
        int c1 = 0;
        int c2 = 0;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 6'b10_1111;
        tick();
        wr_addr = 4'd2; wr_data = 6'b11_1111;
        tick();
        wr_addr = 4'd9; wr_data = 6'b10_1111;
        tick();
        wr_addr = 4'd13; wr_data = 6'b11_1111;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL blink t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
            if (k >= FRAME && (t - 1) % FRAME < SCAN_DIV) begin
                if (kled_tri[1]) c1++;
                if (kled_tri[2]) c2++;
            end
        end
        vectors++;
        if (c1 != 0 || c2 != 32) begin
            miscompares++;
            $display("FAIL blink_row0 got %0d/%0d want 0/32", c1, c2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4 * FRAME; k++) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = 4'($urandom_range(0, N - 1));
            wr_data = 6'($urandom);
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL random t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int lit = 0;
        while (t % FRAME != 2 * SCAN_DIV + 30) tick();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({aled, kled_tri, frame_start} !== 9'd0) begin
            miscompares++;
            $display("FAIL async_reset got %b/%b/%b want 0", aled, kled_tri, frame_start);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            wr_en = 1'b0;
            tick();
            vectors++;
            if ({aled, kled_tri, frame_start} !== {exp_aled, exp_kled, exp_fs}) begin
                miscompares++;
                $display("FAIL post_reset t=%0d got %b/%b/%b want %b/%b/%b", t - 1,
                         aled, kled_tri, frame_start, exp_aled, exp_kled, exp_fs);
            end
            if (kled_tri != 4'd0) lit++;
        end
        vectors++;
        if (lit != 0) begin
            miscompares++;
            $display("FAIL config_cleared got %0d lit clocks want 0", lit);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_on();
        test_pwm();
        test_shadow();
        test_blink();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
